thread_fetch_sequencer: RTL and testbench

Round-robin thread scheduler on the read side of the per-thread PC store in the barrel-threaded core. It generates the thread index used to read each thread's PC and issues fetch requests for active threads. It delays each issued thread index by the pipeline depth to produce the execute-stage thread index that the PC store uses for its write-back. After reset it runs an init sequence that writes the startup address into every PC entry, then manages a per-thread run/halt mask.

---
 rtl/thread_fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_thread_fetch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/thread_fetch_sequencer.sv
// thread_fetch_sequencer
//   Read-side scheduler for the per-thread PC store of the barrel-threaded core.
//   After reset it writes STARTUP_ADDR into every PC entry (INIT). It then
//   steps a round-robin thread counter every cycle (RUN). The counter addresses
//   the PC store and issues a fetch for each thread that is enabled in the run
//   mask. Each issued slot is delayed by PIPE_DEPTH cycles to give the
//   execute-stage thread index used for PC write-back.
//
// Ports
//   clk, reset (async, active-low)
//   i_enable                  global run; low suppresses fetch issue
//   i_pcreg_out               PC store read data for o_thread_index_counter
//   i_start_valid/_thread     set a thread's run-mask bit
//   i_halt_valid/_thread      clear a thread's run-mask bit (wins on a tie)
//   o_thread_index_counter    PC store read address
//   o_fetch_valid/_pc/_thread fetch issued this cycle
//   o_thread_index_execute    thread at the execute stage
//   o_exec_valid              the execute slot holds an issued fetch
//   o_init_we/_addr/_data     PC store init write port
//   o_init_busy               high while init is running
//   o_thread_active           current run mask
module thread_fetch_sequencer #(
  parameter int                  DWIDTH       = 32,
  parameter int                  DEPTH        = 16,
  parameter int                  PIPE_DEPTH   = 4,
  parameter logic [DWIDTH-1:0]   STARTUP_ADDR = '0,
  parameter logic [DEPTH-1:0]    INIT_MASK    = {DEPTH{1'b1}},
  localparam int                 TW           = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [DWIDTH-1:0] i_pcreg_out,
  input  logic              i_start_valid,
  input  logic [TW-1:0]     i_start_thread,
  input  logic              i_halt_valid,
  input  logic [TW-1:0]     i_halt_thread,
  output logic [TW-1:0]     o_thread_index_counter,
  output logic              o_fetch_valid,
  output logic [DWIDTH-1:0] o_fetch_pc,
  output logic [TW-1:0]     o_fetch_thread,
  output logic [TW-1:0]     o_thread_index_execute,
  output logic              o_exec_valid,
  output logic              o_init_we,
  output logic [TW-1:0]     o_init_addr,
  output logic [DWIDTH-1:0] o_init_data,
  output logic              o_init_busy,
  output logic [DEPTH-1:0]  o_thread_active
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         init_ptr_q, init_ptr_d;
  logic [TW-1:0]         counter_q, counter_d;
  logic [DEPTH-1:0]      mask_q, mask_d;
  logic [PIPE_DEPTH-1:0] pipe_vld_q, pipe_vld_d;
  logic [TW-1:0]         pipe_thr_q [PIPE_DEPTH];
  logic [TW-1:0]         pipe_thr_d [PIPE_DEPTH];
  logic                  fetch_valid;

  assign fetch_valid = (state_q == ST_RUN) && i_enable && mask_q[counter_q];

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    counter_d  = counter_q;
    mask_d     = mask_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == TW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          mask_d  = INIT_MASK;
        end
      end
      default: begin
        // Counter never stalls so the barrel interleave stays strict.
        counter_d = counter_q + 1'b1;
        // Halt is applied after start so it wins on the same thread.
        if (i_start_valid) mask_d[i_start_thread] = 1'b1;
        if (i_halt_valid)  mask_d[i_halt_thread]  = 1'b0;
      end
    endcase
  end

  // Execute pipeline: the thread field shifts even for empty slots so the
  // execute index remains a continuous round-robin sequence.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_vld_d[0] = fetch_valid;
    pipe_thr_d[0] = counter_q;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_thr_d[i] = pipe_thr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      counter_q  <= '0;
      mask_q     <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_thr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      counter_q  <= counter_d;
      mask_q     <= mask_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_thr_q[i] <= pipe_thr_d[i];
    end
  end

  assign o_thread_index_counter = counter_q;
  assign o_fetch_valid          = fetch_valid;
  assign o_fetch_pc             = i_pcreg_out;
  assign o_fetch_thread         = counter_q;
  assign o_thread_index_execute = pipe_thr_q[PIPE_DEPTH-1];
  assign o_exec_valid           = pipe_vld_q[PIPE_DEPTH-1];
  // Gated by reset so no write strobe escapes while reset is held; the first
  // write (entry 0) is presented in the cycle reset is released.
  assign o_init_we              = (state_q == ST_INIT) && reset;
  assign o_init_addr            = init_ptr_q;
  assign o_init_data            = STARTUP_ADDR;
  assign o_init_busy            = (state_q == ST_INIT);
  assign o_thread_active        = mask_q;

endmodule

// File: tb/tb_thread_fetch_sequencer.sv
module tb_thread_fetch_sequencer;

  localparam int DWIDTH = 32;
  localparam int DEPTH  = 16;
  localparam int PIPE   = 4;
  localparam int TW     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_enable;
  logic [DWIDTH-1:0] i_pcreg_out;
  logic              i_start_valid;
  logic [TW-1:0]     i_start_thread;
  logic              i_halt_valid;
  logic [TW-1:0]     i_halt_thread;
  logic [TW-1:0]     o_thread_index_counter;
  logic              o_fetch_valid;
  logic [DWIDTH-1:0] o_fetch_pc;
  logic [TW-1:0]     o_fetch_thread;
  logic [TW-1:0]     o_thread_index_execute;
  logic              o_exec_valid;
  logic              o_init_we;
  logic [TW-1:0]     o_init_addr;
  logic [DWIDTH-1:0] o_init_data;
  logic              o_init_busy;
  logic [DEPTH-1:0]  o_thread_active;

  int n_chk  = 0;
  int n_pass = 0;

  thread_fetch_sequencer #(
    .DWIDTH(DWIDTH), .DEPTH(DEPTH), .PIPE_DEPTH(PIPE),
    .STARTUP_ADDR(32'h100), .INIT_MASK(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_pcreg_out(i_pcreg_out),
    .i_start_valid(i_start_valid), .i_start_thread(i_start_thread),
    .i_halt_valid(i_halt_valid), .i_halt_thread(i_halt_thread),
    .o_thread_index_counter(o_thread_index_counter), .o_fetch_valid(o_fetch_valid),
    .o_fetch_pc(o_fetch_pc), .o_fetch_thread(o_fetch_thread),
    .o_thread_index_execute(o_thread_index_execute), .o_exec_valid(o_exec_valid),
    .o_init_we(o_init_we), .o_init_addr(o_init_addr), .o_init_data(o_init_data),
    .o_init_busy(o_init_busy), .o_thread_active(o_thread_active)
  );

  always #5 clk = ~clk;

  // PC store model: the read data tracks the read address.
  assign i_pcreg_out = 32'h200 + {28'd0, o_thread_index_counter};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_busy",    32'(o_init_busy), 32'd1);
    chk("rst_we",      32'(o_init_we), 32'd0);
    chk("rst_fv",      32'(o_fetch_valid), 32'd0);
    chk("rst_ev",      32'(o_exec_valid), 32'd0);
    chk("rst_mask",    32'(o_thread_active), 32'd0);
    chk("rst_cnt",     32'(o_thread_index_counter), 32'd0);
    chk("rst_exidx",   32'(o_thread_index_execute), 32'd0);
    chk("rst_addr",    32'(o_init_addr), 32'd0);
  endtask

  initial begin
    logic [3:0] cnt;
    reset = 1'b0; i_enable = 1'b1;
    i_start_valid = 1'b0; i_start_thread = '0;
    i_halt_valid = 1'b0;  i_halt_thread = '0;
    #2;
    check_reset_vals();

    // Release reset; init sequence writes entries 0..15.
    tick();
    reset = 1'b1;
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) tick();
      // Requests during init must be ignored; mask still loads INIT_MASK.
      if (k == 15) begin
        i_halt_valid = 1'b1; i_halt_thread = 4'd4;
        i_start_valid = 1'b1; i_start_thread = 4'd2;
      end
      #1;
      chk("init_we",   32'(o_init_we), 32'd1);
      chk("init_addr", 32'(o_init_addr), 32'(k));
      chk("init_data", o_init_data, 32'h100);
      chk("init_busy", 32'(o_init_busy), 32'd1);
      chk("init_mask", 32'(o_thread_active), 32'd0);
      chk("init_cnt",  32'(o_thread_index_counter), 32'd0);
      chk("init_fv",   32'(o_fetch_valid), 32'd0);
    end

    // RUN phase: rc is the run cycle, counter expected = rc mod 16.
    for (int rc = 0; rc < 40; rc++) begin
      tick();
      i_start_valid = 1'b0; i_halt_valid = 1'b0;
      i_enable = !(rc >= 32 && rc <= 34);
      case (rc)
        18: begin i_halt_valid = 1'b1; i_halt_thread = 4'd5; end
        26: begin i_start_valid = 1'b1; i_start_thread = 4'd7;
                  i_halt_valid = 1'b1; i_halt_thread = 4'd7; end
        27: begin i_start_valid = 1'b1; i_start_thread = 4'd5;
                  i_halt_valid = 1'b1; i_halt_thread = 4'd9; end
        28: begin i_start_valid = 1'b1; i_start_thread = 4'd9;
                  i_halt_valid = 1'b1; i_halt_thread = 4'd7; end
        29: begin i_start_valid = 1'b1; i_start_thread = 4'd0; end
        default: ;
      endcase
      #1;
      cnt = 4'(rc);
      chk("run_cnt", 32'(o_thread_index_counter), 32'(cnt));
      if (rc == 0) begin
        chk("run_busy", 32'(o_init_busy), 32'd0);
        chk("run_we",   32'(o_init_we), 32'd0);
        chk("exec_v0",  32'(o_exec_valid), 32'd0);
      end
      if (rc <= 24) chk("fv", 32'(o_fetch_valid), (rc == 21) ? 32'd0 : 32'd1);
      if (rc >= 32 && rc <= 35) chk("fv_en", 32'(o_fetch_valid), (rc == 35) ? 32'd1 : 32'd0);
      if (rc == 39) chk("fv_t7_halted", 32'(o_fetch_valid), 32'd0);
      if (rc <= 17) begin
        chk("fthread", 32'(o_fetch_thread), 32'(cnt));
        chk("fpc",     o_fetch_pc, 32'h200 + 32'(cnt));
      end
      case (rc)
        0:  chk("mask_init",  32'(o_thread_active), 32'hFFFF);
        19: chk("mask_h5",    32'(o_thread_active), 32'hFFDF);
        27: chk("mask_s7h7",  32'(o_thread_active), 32'hFF5F);
        28: chk("mask_s5h9",  32'(o_thread_active), 32'hFD7F);
        29: chk("mask_s9h7",  32'(o_thread_active), 32'hFF7F);
        30: chk("mask_s0nop", 32'(o_thread_active), 32'hFF7F);
        default: ;
      endcase
      if (rc == 7 || rc == 25 || rc == 39) begin
        chk("exec_idx", 32'(o_thread_index_execute), (rc == 25) ? 32'd5 : 32'd3);
        chk("exec_v",   32'(o_exec_valid), (rc == 25) ? 32'd0 : 32'd1);
      end
      if (rc >= 36 && rc <= 38) begin
        chk("exec_idx_en", 32'(o_thread_index_execute), 32'(rc - 36));
        chk("exec_v_en",   32'(o_exec_valid), 32'd0);
      end
    end

    // Mid-RUN reset.
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rel1_we",   32'(o_init_we), 32'd1);
    chk("rel1_addr", 32'(o_init_addr), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      #1;
      chk("rel1_addr_k", 32'(o_init_addr), 32'(k));
      chk("rel1_mask",   32'(o_thread_active), 32'd0);
    end

    // Reset at init cycle 8.
    reset = 1'b0;
    #1;
    check_reset_vals();
    tick();
    reset = 1'b1;
    #1;
    chk("rel2_we",   32'(o_init_we), 32'd1);
    chk("rel2_addr", 32'(o_init_addr), 32'd0);
    for (int k = 1; k < DEPTH; k++) tick();
    #1;
    chk("rel2_addr15", 32'(o_init_addr), 32'd15);
    chk("rel2_busy15", 32'(o_init_busy), 32'd1);
    tick();
    #1;
    chk("rel2_busy", 32'(o_init_busy), 32'd0);
    chk("rel2_mask", 32'(o_thread_active), 32'hFFFF);
    chk("rel2_cnt",  32'(o_thread_index_counter), 32'd0);
    chk("rel2_fv",   32'(o_fetch_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
